// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state encoding and the
// 2-of-3 majority used for bit decisions.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: down-counter that pulses tick at terminal count,
// every DIV clocks; clr restarts the phase.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == '0) begin
      cnt <= CW'(DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !clr;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with majority-vote sampling, parity/frame/break
// detection and a valid/ready output holding register with overrun reporting.
//
// state         | meaning
// ST_IDLE       | line idle, waiting for a synchronised falling edge
// ST_START      | verifying the start bit (glitch rejection)
// ST_DATA       | shifting in DATA_LEN bits, LSB first
// ST_PARITY     | sampling the parity bit and latching any mismatch
// ST_STOP       | checking stop bits; frame completes at last mid-stop decision
// ST_BREAK_WAIT | break received, waiting for the line to return high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_LEN   = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic                uart_rx,
  output logic [DATA_LEN-1:0] rx_dat,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                overrun
);

  localparam int DIV  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int SW   = $clog2(OVERSAMPLE);
  localparam int HALF = OVERSAMPLE / 2;

  if (DATA_LEN < 5 || DATA_LEN > 9) begin : g_bad_len
    $error("uart_rx_cfg: DATA_LEN must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
    $error("uart_rx_cfg: OVERSAMPLE must be 8 or 16");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_par
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_cfg: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
  end

  rx_state_e           state, state_nx;
  logic                sync1, rx_s, rx_d;
  logic                tick, clr, fall, dec, maj;
  logic [SW-1:0]       s_cnt;
  logic                m0, m1;
  logic [DATA_LEN-1:0] shreg;
  logic [3:0]          bit_cnt;
  logic                par_bit, par_err_r, stop_fe;
  logic                done, brk, brk_cand;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;
  assign clr  = (state == ST_IDLE) && fall;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_sys (clk_sys),
    .rst     (rst),
    .clr     (clr),
    .tick    (tick)
  );

  assign dec      = tick && (s_cnt == SW'(HALF + 1));
  assign maj      = maj3(m0, m1, rx_s);
  assign brk_cand = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit);

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    brk      = 1'b0;
    case (state)
      ST_IDLE:   if (fall) state_nx = ST_START;
      ST_START:  if (dec) state_nx = maj ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (dec && bit_cnt == 4'(DATA_LEN - 1))
          state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (dec) state_nx = ST_STOP;
      ST_STOP: begin
        if (dec) begin
          // A break is decided on the first stop bit, even with two stop bits.
          if (bit_cnt == 4'd0 && brk_cand && !maj) begin
            done     = 1'b1;
            brk      = 1'b1;
            state_nx = ST_BREAK_WAIT;
          end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
            done     = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_BREAK_WAIT: if (rx_s) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      m0        <= 1'b1;
      m1        <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      par_err_r <= 1'b0;
      stop_fe   <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr) begin
        s_cnt     <= '0;
        par_err_r <= 1'b0;
        stop_fe   <= 1'b0;
      end else if (tick) begin
        s_cnt <= s_cnt + 1'b1;
      end
      if (tick && s_cnt == SW'(HALF - 1)) m0 <= rx_s;
      if (tick && s_cnt == SW'(HALF))     m1 <= rx_s;
      if (state != state_nx) begin
        bit_cnt <= '0;
      end else if (dec && (state == ST_DATA || state == ST_STOP)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (dec && state == ST_DATA) shreg <= {maj, shreg[DATA_LEN-1:1]};
      if (dec && state == ST_PARITY) begin
        par_bit   <= maj;
        par_err_r <= (PARITY == PAR_ODD) ? (maj == ^shreg) : (maj != ^shreg);
      end
      if (dec && state == ST_STOP && !maj) stop_fe <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rx_dat     <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_dat     <= shreg;
          parity_err <= par_err_r;
          frame_err  <= stop_fe | ~maj;
          break_det  <= brk;
          rx_valid   <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at 160 clocks per bit: 8N1 main instance plus
// 8E1 and 8O1 instances sharing the same serial line.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int BIT_CLKS = 160;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       ready_p = 1'b1;
  logic [7:0] rx_dat, dat_e, dat_o;
  logic       rx_valid, parity_err, frame_err, break_det, overrun;
  logic       val_e, pe_e, fe_e, bd_e, ov_e;
  logic       val_o, pe_o, fe_o, bd_o, ov_o;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] last_dat = '0;
  logic last_pe = 1'b0, last_fe = 1'b0, last_bd = 1'b0;
  int h0, o0;

  always #5 clk_sys = ~clk_sys;

  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_LEN(8),
                .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) dut (
    .clk_sys(clk_sys), .rst(rst), .uart_rx(uart_rx), .rx_dat(rx_dat),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det), .overrun(overrun));

  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_LEN(8),
                .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) dut_e (
    .clk_sys(clk_sys), .rst(rst), .uart_rx(uart_rx), .rx_dat(dat_e),
    .rx_valid(val_e), .rx_ready(ready_p), .parity_err(pe_e),
    .frame_err(fe_e), .break_det(bd_e), .overrun(ov_e));

  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_LEN(8),
                .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) dut_o (
    .clk_sys(clk_sys), .rst(rst), .uart_rx(uart_rx), .rx_dat(dat_o),
    .rx_valid(val_o), .rx_ready(ready_p), .parity_err(pe_o),
    .frame_err(fe_o), .break_det(bd_o), .overrun(ov_o));

  // Record every accepted word and every overrun pulse of the main instance.
  always @(posedge clk_sys) begin
    if (rx_valid && rx_ready) begin
      hs_cnt   <= hs_cnt + 1;
      last_dat <= rx_dat;
      last_pe  <= parity_err;
      last_fe  <= frame_err;
      last_bd  <= break_det;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    tick_n(BIT_CLKS);
  endtask

  task automatic send_head(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  // par < 0 means no parity bit on the line.
  task automatic send_frame(input logic [7:0] d, input int par, input int idle);
    send_head(d);
    if (par >= 0) send_bit(par[0]);
    send_bit(1'b1);
    if (idle > 0) tick_n(idle);
  endtask

  initial begin
    tick_n(5);
    chk("rst_dat", 32'(rx_dat), 32'h0);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_flags", {28'h0, parity_err, frame_err, break_det, overrun}, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    tick_n(20);

    // 8N1 0xA5 with exact valid latency after the mid-stop decision
    h0 = hs_cnt;
    send_head(8'hA5);
    uart_rx = 1'b1;
    tick_n(102);
    chk("a5_valid_before", 32'(rx_valid), 32'h0);
    tick_n(1);
    chk("a5_valid_after", 32'(rx_valid), 32'h1);
    chk("a5_dat", 32'(rx_dat), 32'hA5);
    chk("a5_flags", {29'h0, parity_err, frame_err, break_det}, 32'h0);
    tick_n(57 + 400);
    chk("a5_count", 32'(hs_cnt - h0), 32'h1);

    // 0x03 with parity bit 1: even parity mismatch, odd parity fine
    send_frame(8'h03, 1, 400);
    chk("even_dat", 32'(dat_e), 32'h03);
    chk("even_perr", 32'(pe_e), 32'h1);
    chk("even_ferr", 32'(fe_e), 32'h0);
    chk("odd_dat", 32'(dat_o), 32'h03);
    chk("odd_perr", 32'(pe_o), 32'h0);

    // 40-clock start glitch is rejected, next frame received
    h0 = hs_cnt;
    uart_rx = 1'b0;
    tick_n(40);
    uart_rx = 1'b1;
    tick_n(400);
    chk("glitch_count", 32'(hs_cnt - h0), 32'h0);
    chk("glitch_valid", 32'(rx_valid), 32'h0);
    chk("glitch_state", 32'(dut.state), 32'(ST_IDLE));
    send_frame(8'h5A, -1, 400);
    chk("5a_count", 32'(hs_cnt - h0), 32'h1);
    chk("5a_dat", 32'(last_dat), 32'h5A);
    chk("5a_ferr", 32'(last_fe), 32'h0);

    // overrun: back-to-back 0x11, 0x22 with no consumer
    rx_ready = 1'b0;
    o0 = ov_cnt;
    send_frame(8'h11, -1, 0);
    send_frame(8'h22, -1, 400);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    chk("ovr_dat", 32'(rx_dat), 32'h11);
    chk("ovr_pulses", 32'(ov_cnt - o0), 32'h1);
    // handshake in the completion cycle of 0x33: loads, no overrun
    send_head(8'h33);
    uart_rx = 1'b1;
    tick_n(102);
    rx_ready = 1'b1;
    tick_n(1);
    rx_ready = 1'b0;
    chk("same_cyc_valid", 32'(rx_valid), 32'h1);
    chk("same_cyc_dat", 32'(rx_dat), 32'h33);
    chk("same_cyc_consumed", 32'(last_dat), 32'h11);
    tick_n(57 + 400);
    chk("same_cyc_pulses", 32'(ov_cnt - o0), 32'h1);
    rx_ready = 1'b1;
    tick_n(2);
    chk("drain_valid", 32'(rx_valid), 32'h0);

    // break: line low for 30 bit times
    h0 = hs_cnt;
    uart_rx = 1'b0;
    tick_n(20 * BIT_CLKS);
    chk("brk_state", 32'(dut.state), 32'(ST_BREAK_WAIT));
    tick_n(10 * BIT_CLKS);
    chk("brk_count", 32'(hs_cnt - h0), 32'h1);
    chk("brk_dat", 32'(last_dat), 32'h00);
    chk("brk_bd", 32'(last_bd), 32'h1);
    chk("brk_fe", 32'(last_fe), 32'h1);
    uart_rx = 1'b1;
    tick_n(400);
    chk("brk_release_state", 32'(dut.state), 32'(ST_IDLE));
    chk("brk_release_count", 32'(hs_cnt - h0), 32'h1);
    send_frame(8'h7E, -1, 400);
    chk("7e_count", 32'(hs_cnt - h0), 32'h2);
    chk("7e_dat", 32'(last_dat), 32'h7E);
    chk("7e_flags", {30'h0, last_bd, last_fe}, 32'h0);

    // reset in the middle of data bit 4 (line high there)
    h0 = hs_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h35 >> i));
    uart_rx = 1'b1;
    tick_n(80);
    rst = 1'b1;
    tick_n(3);
    chk("mid_rst_dat", 32'(rx_dat), 32'h0);
    chk("mid_rst_valid", 32'(rx_valid), 32'h0);
    chk("mid_rst_flags", {28'h0, parity_err, frame_err, break_det, overrun}, 32'h0);
    rst = 1'b0;
    tick_n(2000);
    chk("post_rst_count", 32'(hs_cnt - h0), 32'h0);
    chk("post_rst_state", 32'(dut.state), 32'(ST_IDLE));
    send_frame(8'hC3, -1, 400);
    chk("c3_count", 32'(hs_cnt - h0), 32'h1);
    chk("c3_dat", 32'(last_dat), 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
